// File: rtl/minibus_arbiter.sv
// Round-robin/fixed-priority arbiter sharing one minibus master port; 1-cycle grant latency, ack/rdata routed back combinationally.
// Holds the latched request until s_ack or timeout; requesters wait (no buffering) while another is served.
module minibus_arbiter #(
  parameter int MASTER_COUNT   = 2,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int IDW            = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [MASTER_COUNT*32-1:0] m_addr,
  input  logic [MASTER_COUNT*2-1:0]  m_width,
  input  logic [MASTER_COUNT*32-1:0] m_wdata,
  input  logic [MASTER_COUNT-1:0]    m_ren,
  input  logic [MASTER_COUNT-1:0]    m_wen,
  output logic [MASTER_COUNT-1:0]    m_ack,
  output logic [MASTER_COUNT-1:0]    m_err,
  output logic [31:0]                m_rdata,
  output logic [31:0]                s_addr,
  output logic [1:0]                 s_width,
  output logic [31:0]                s_wdata,
  output logic                       s_ren,
  output logic                       s_wen,
  input  logic                       s_ack,
  input  logic [31:0]                s_rdata,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy
);

  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TLAST = TCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
    logic        ren;
    logic        wen;
  } req_t;

  state_t                  state_q, state_d;
  req_t                    lat_q, lat_d;
  logic [IDW-1:0]          gnt_q, gnt_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [TCW-1:0]          tmo_q, tmo_d;
  logic [MASTER_COUNT-1:0] req;
  logic                    any_req;
  logic                    found;
  logic [IDW-1:0]          winner;
  logic [IDW-1:0]          sel;
  logic                    timeout_hit;
  int                      idx;

  assign req     = m_ren | m_wen;
  assign any_req = |req;

  // Scan starts at the pointer (rotating) or at index 0 (fixed priority).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int off = 0; off < MASTER_COUNT; off++) begin
      idx = (ROUND_ROBIN != 0) ? (int'(ptr_q) + off) % MASTER_COUNT : off;
      sel = IDW'(idx);
      if (!found && req[sel]) begin
        winner = sel;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    m_ack       = '0;
    m_err       = '0;
    m_rdata     = '0;
    timeout_hit = 1'b0;
    if (state_q == BUSY) begin
      if (s_ack) begin
        m_ack[gnt_q] = 1'b1;
        m_rdata      = s_rdata;
      end else if (TIMEOUT_CYCLES > 0 && tmo_q == TLAST) begin
        m_err[gnt_q] = 1'b1;
        timeout_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        lat_d.ren = 1'b0;
        lat_d.wen = 1'b0;
        if (any_req) begin
          lat_d.addr  = m_addr[winner*32 +: 32];
          lat_d.width = m_width[winner*2 +: 2];
          lat_d.wdata = m_wdata[winner*32 +: 32];
          // A request with both enables set is treated as a write.
          lat_d.wen   = m_wen[winner];
          lat_d.ren   = m_ren[winner] & ~m_wen[winner];
          gnt_d       = winner;
          tmo_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (s_ack || timeout_hit) begin
          lat_d.ren = 1'b0;
          lat_d.wen = 1'b0;
          state_d   = RELEASE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RELEASE: begin
        if (ROUND_ROBIN != 0)
          ptr_d = (int'(gnt_q) == MASTER_COUNT - 1) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign s_addr   = lat_q.addr;
  assign s_width  = lat_q.width;
  assign s_wdata  = lat_q.wdata;
  assign s_ren    = lat_q.ren;
  assign s_wen    = lat_q.wen;
  assign grant_id = gnt_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_minibus_arbiter.sv
// Bench for minibus_arbiter: a rotating-priority instance with a 4-cycle timeout and a fixed-priority instance share stimulus.
module tb_minibus_arbiter;

  localparam int MC = 3;

  logic          tb_clk = 1'b0;
  logic          nrst;
  logic [MC*32-1:0] m_addr, m_wdata;
  logic [MC*2-1:0]  m_width;
  logic [MC-1:0]    m_ren, m_wen;
  logic          s_ack;
  logic [31:0]   s_rdata;

  logic [MC-1:0] r_ack, r_err, f_ack, f_err;
  logic [31:0]   r_rdata, r_addr, r_wdata, f_rdata, f_addr, f_wdata;
  logic [1:0]    r_width, f_width, r_gid, f_gid;
  logic          r_ren, r_wen, r_busy, f_ren, f_wen, f_busy;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  minibus_arbiter #(.MASTER_COUNT(MC), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_rr (
    .clk(tb_clk), .nrst(nrst), .m_addr(m_addr), .m_width(m_width), .m_wdata(m_wdata),
    .m_ren(m_ren), .m_wen(m_wen), .m_ack(r_ack), .m_err(r_err), .m_rdata(r_rdata),
    .s_addr(r_addr), .s_width(r_width), .s_wdata(r_wdata), .s_ren(r_ren), .s_wen(r_wen),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_id(r_gid), .busy(r_busy));

  minibus_arbiter #(.MASTER_COUNT(MC), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_fp (
    .clk(tb_clk), .nrst(nrst), .m_addr(m_addr), .m_width(m_width), .m_wdata(m_wdata),
    .m_ren(m_ren), .m_wen(m_wen), .m_ack(f_ack), .m_err(f_err), .m_rdata(f_rdata),
    .s_addr(f_addr), .s_width(f_width), .s_wdata(f_wdata), .s_ren(f_ren), .s_wen(f_wen),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant_id(f_gid), .busy(f_busy));

  // Every step lands 1ns after a falling edge, so exactly one rising edge has passed.
  task automatic tick;
    @(negedge tb_clk);
    #1;
  endtask

  task automatic clear_reqs;
    m_addr  = '0;
    m_width = '0;
    m_wdata = '0;
    m_ren   = '0;
    m_wen   = '0;
  endtask

  task automatic set_req(input int i, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [1:0] w, input logic [31:0] d);
    m_addr[i*32 +: 32]  = addr;
    m_width[i*2 +: 2]   = w;
    m_wdata[i*32 +: 32] = d;
    m_ren[i]            = ren;
    m_wen[i]            = wen;
  endtask

  task automatic do_reset;
    nrst = 1'b0;
    clear_reqs();
    s_ack   = 1'b0;
    s_rdata = '0;
    #1;
    nrst = 1'b1;
  endtask

  // Reference arbitration: first requester at or after ptr, wrapping.
  function automatic int model_winner(input logic [MC-1:0] mask, input int ptr);
    for (int k = 0; k < MC; k++)
      if (mask[(ptr + k) % MC]) return (ptr + k) % MC;
    return -1;
  endfunction

  task automatic test_reset;
    nrst = 1'b0;
    clear_reqs();
    s_ack   = 1'b1;
    s_rdata = 32'hFFFF_FFFF;
    set_req(0, 1'b1, 1'b1, 32'h1234, 2'b10, 32'h5555);
    tick();
    checks++;
    if ({r_busy, r_ren, r_wen, r_addr, r_width, r_wdata, r_gid, r_ack, r_err, r_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rr_outputs: got busy=%b ren=%b wen=%b addr=%h gid=%0d ack=%b err=%b rdata=%h required all zero",
               r_busy, r_ren, r_wen, r_addr, r_gid, r_ack, r_err, r_rdata);
    end
    checks++;
    if ({f_busy, f_ren, f_wen, f_addr, f_gid, f_ack, f_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_fp_outputs: got busy=%b ren=%b wen=%b addr=%h ack=%b required all zero",
               f_busy, f_ren, f_wen, f_addr, f_ack);
    end
    nrst = 1'b1;
    clear_reqs();
    s_ack = 1'b0;
    tick();
    checks++;
    if ({r_busy, r_ren, r_wen} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_req: got busy/ren/wen=%b required 000", {r_busy, r_ren, r_wen});
    end
  endtask

  task automatic test_single_write;
    do_reset();
    set_req(0, 1'b0, 1'b1, 32'h4000, 2'b10, 32'h1234_5678);
    #1;
    checks++;
    if ({r_busy, r_wen} !== 2'b00) begin
      errors++;
      $display("FAIL write_pre_edge: got busy/wen=%b required 00", {r_busy, r_wen});
    end
    tick();
    checks++;
    if ({r_wen, r_ren, r_addr, r_width, r_wdata, r_gid, r_busy} !== {2'b10, 32'h4000, 2'b10, 32'h1234_5678, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL write_latch: got wen=%b ren=%b addr=%h width=%b data=%h gid=%0d busy=%b required wen=1 ren=0 addr=4000 width=10 data=12345678 gid=0 busy=1",
               r_wen, r_ren, r_addr, r_width, r_wdata, r_gid, r_busy);
    end
    clear_reqs();
    s_ack = 1'b1;
    #1;
    checks++;
    if ({r_ack, r_err} !== {3'b001, 3'b000}) begin
      errors++;
      $display("FAIL write_ack: got ack=%b err=%b required ack=001 err=000", r_ack, r_err);
    end
    tick();
    checks++;
    if ({r_wen, r_ren, r_busy, r_ack} !== {3'b001, 3'b000}) begin
      errors++;
      $display("FAIL write_release: got wen=%b ren=%b busy=%b ack=%b required 0 0 1 000", r_wen, r_ren, r_busy, r_ack);
    end
    s_ack = 1'b0;
    tick();
    checks++;
    if (r_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: got busy=%b required 0", r_busy);
    end
  endtask

  task automatic test_read_return;
    do_reset();
    s_rdata = 32'hDEAD_DEAD;
    set_req(1, 1'b1, 1'b0, 32'h0, 2'b10, 32'h0);
    tick();
    checks++;
    if ({r_gid, r_ren, r_wen, r_addr} !== {2'd1, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL read_latch: got gid=%0d ren=%b wen=%b addr=%h required gid=1 ren=1 wen=0 addr=0", r_gid, r_ren, r_wen, r_addr);
    end
    clear_reqs();
    #1;
    checks++;
    if ({r_ack, r_rdata} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL read_no_ack_rdata: got ack=%b rdata=%h required 000 00000000", r_ack, r_rdata);
    end
    tick();
    s_ack   = 1'b1;
    s_rdata = 32'hBEEF_BEEF;
    #1;
    checks++;
    if ({r_ack, r_rdata} !== {3'b010, 32'hBEEF_BEEF}) begin
      errors++;
      $display("FAIL read_ack_data: got ack=%b rdata=%h required 010 beefbeef", r_ack, r_rdata);
    end
    tick();
    s_ack = 1'b0;
    tick();
  endtask

  task automatic test_rr_fairness;
    logic [1:0] exp_rr;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hA0, 2'b10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'hB0, 2'b10, 32'h0);
    for (int n = 0; n < 4; n++) begin
      exp_rr = 2'(n % 2);
      tick();
      checks++;
      if (r_gid !== exp_rr) begin
        errors++;
        $display("FAIL rr_sequence[%0d]: got gid=%0d required %0d", n, r_gid, exp_rr);
      end
      checks++;
      if ({f_gid, f_busy} !== {2'd0, 1'b1}) begin
        errors++;
        $display("FAIL fixed_sequence[%0d]: got gid=%0d busy=%b required gid=0 busy=1", n, f_gid, f_busy);
      end
      s_ack = 1'b1;
      #1;
      checks++;
      if (f_ack !== 3'b001) begin
        errors++;
        $display("FAIL fixed_ack[%0d]: got %b required 001", n, f_ack);
      end
      tick();
      s_ack = 1'b0;
      tick();
    end
  endtask

  task automatic test_hold_mid_txn;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h10, 2'b01, 32'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h20, 2'b00, 32'h0);
    set_req(2, 1'b0, 1'b1, 32'h30, 2'b10, 32'h77);
    tick();
    checks++;
    if ({r_addr, r_width, r_ren, r_wen, r_gid} !== {32'h10, 2'b01, 2'b10, 2'd0}) begin
      errors++;
      $display("FAIL hold_latched: got addr=%h width=%b ren=%b wen=%b gid=%0d required addr=10 width=01 ren=1 wen=0 gid=0",
               r_addr, r_width, r_ren, r_wen, r_gid);
    end
    s_ack = 1'b1;
    #1;
    checks++;
    if (r_ack !== 3'b001) begin
      errors++;
      $display("FAIL hold_ack: got %b required 001", r_ack);
    end
    tick();
    clear_reqs();
    s_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    set_req(2, 1'b1, 1'b0, 32'h80, 2'b10, 32'h0);
    tick();
    clear_reqs();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({r_err, r_ren, r_busy} !== {3'b000, 2'b11}) begin
        errors++;
        $display("FAIL timeout_early[%0d]: got err=%b ren=%b busy=%b required 000 1 1", c, r_err, r_ren, r_busy);
      end
      tick();
    end
    checks++;
    if ({r_err, r_ack} !== {3'b100, 3'b000}) begin
      errors++;
      $display("FAIL timeout_err: got err=%b ack=%b required 100 000", r_err, r_ack);
    end
    checks++;
    if ({f_err, f_busy} !== {3'b000, 1'b1}) begin
      errors++;
      $display("FAIL fixed_no_timeout: got err=%b busy=%b required 000 1", f_err, f_busy);
    end
    tick();
    checks++;
    if ({r_ren, r_busy, r_err} !== {2'b01, 3'b000}) begin
      errors++;
      $display("FAIL timeout_release: got ren=%b busy=%b err=%b required 0 1 000", r_ren, r_busy, r_err);
    end
    tick();
    s_ack = 1'b1;
    #1;
    checks++;
    if ({r_busy, r_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ack_ignored: got busy=%b ack=%b required 0 000", r_busy, r_ack);
    end
    checks++;
    if (f_ack !== 3'b100) begin
      errors++;
      $display("FAIL fixed_late_ack: got %b required 100", f_ack);
    end
    tick();
    s_ack = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    set_req(1, 1'b0, 1'b1, 32'h100, 2'b10, 32'h11);
    tick();
    clear_reqs();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    tick();
    set_req(0, 1'b1, 1'b0, 32'h200, 2'b10, 32'h0);
    tick();
    checks++;
    if ({r_gid, r_busy} !== {2'd0, 1'b1}) begin
      errors++;
      $display("FAIL areset_pre_grant: got gid=%0d busy=%b required 0 1", r_gid, r_busy);
    end
    s_ack = 1'b1;
    nrst  = 1'b0;
    #1;
    checks++;
    if ({r_ack, r_err, r_busy, r_ren, r_wen, r_addr, r_gid, r_rdata} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got ack=%b busy=%b ren=%b addr=%h gid=%0d rdata=%h required all zero",
               r_ack, r_busy, r_ren, r_addr, r_gid, r_rdata);
    end
    nrst  = 1'b1;
    s_ack = 1'b0;
    clear_reqs();
    set_req(1, 1'b1, 1'b0, 32'h300, 2'b10, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h400, 2'b10, 32'h0);
    tick();
    checks++;
    if ({r_gid, r_addr} !== {2'd1, 32'h300}) begin
      errors++;
      $display("FAIL areset_ptr_zero: got gid=%0d addr=%h required gid=1 addr=300", r_gid, r_addr);
    end
    clear_reqs();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic [31:0] a [MC];
    logic [31:0] d [MC];
    logic [1:0]  wd [MC];
    logic        rn [MC];
    logic        wn [MC];
    logic [MC-1:0] mask;
    logic [MC-1:0] onehot;
    logic [31:0] rd;
    int ptr, w, lat;
    do_reset();
    ptr = 0;
    for (int n = 0; n < 40; n++) begin
      mask = '0;
      for (int i = 0; i < MC; i++) begin
        a[i]  = $urandom;
        d[i]  = $urandom;
        wd[i] = 2'($urandom_range(0, 2));
        rn[i] = (n % 10 == 9) ? 1'b0 : 1'($urandom_range(0, 1));
        wn[i] = (n % 10 == 9) ? 1'b0 : 1'($urandom_range(0, 1));
        set_req(i, rn[i], wn[i], a[i], wd[i], d[i]);
        mask[i] = rn[i] | wn[i];
      end
      w = model_winner(mask, ptr);
      tick();
      if (w < 0) begin
        checks++;
        if ({r_busy, r_ren, r_wen} !== 3'b000) begin
          errors++;
          $display("FAIL rand_idle[%0d]: got busy/ren/wen=%b required 000", n, {r_busy, r_ren, r_wen});
        end
        continue;
      end
      onehot = MC'(1 << w);
      checks++;
      if ({r_gid, r_busy, r_addr, r_width, r_wdata} !== {2'(w), 1'b1, a[w], wd[w], d[w]}) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got gid=%0d busy=%b addr=%h width=%b data=%h required gid=%0d busy=1 addr=%h width=%b data=%h",
                 n, r_gid, r_busy, r_addr, r_width, r_wdata, w, a[w], wd[w], d[w]);
      end
      checks++;
      if ({r_ren, r_wen} !== {rn[w] & ~wn[w], wn[w]}) begin
        errors++;
        $display("FAIL rand_dir[%0d]: got ren=%b wen=%b required ren=%b wen=%b", n, r_ren, r_wen, rn[w] & ~wn[w], wn[w]);
      end
      lat = $urandom_range(0, 4);
      for (int c = 1; c <= 4; c++) begin
        m_addr  = {$urandom, $urandom, $urandom};
        m_ren   = MC'($urandom);
        m_wen   = MC'($urandom);
        rd      = $urandom;
        s_rdata = rd;
        s_ack   = (c == lat + 1);
        #1;
        if (s_ack) begin
          checks++;
          if ({r_ack, r_err, r_rdata, r_addr} !== {onehot, 3'b000, rd, a[w]}) begin
            errors++;
            $display("FAIL rand_ack[%0d]: got ack=%b err=%b rdata=%h addr=%h required ack=%b err=000 rdata=%h addr=%h",
                     n, r_ack, r_err, r_rdata, r_addr, onehot, rd, a[w]);
          end
        end else if (c == 4) begin
          checks++;
          if ({r_err, r_ack, r_rdata} !== {onehot, 3'b000, 32'h0}) begin
            errors++;
            $display("FAIL rand_timeout[%0d]: got err=%b ack=%b rdata=%h required err=%b ack=000 rdata=0", n, r_err, r_ack, r_rdata, onehot);
          end
        end else begin
          checks++;
          if ({r_ack, r_err, r_rdata, r_addr, r_busy} !== {3'b000, 3'b000, 32'h0, a[w], 1'b1}) begin
            errors++;
            $display("FAIL rand_wait[%0d.%0d]: got ack=%b err=%b rdata=%h addr=%h busy=%b required 000 000 0 %h 1",
                     n, c, r_ack, r_err, r_rdata, r_addr, r_busy, a[w]);
          end
        end
        if (c == lat + 1 || c == 4) break;
        tick();
      end
      tick();
      checks++;
      if ({r_ren, r_wen, r_busy, r_ack, r_err} !== {3'b001, 6'b0}) begin
        errors++;
        $display("FAIL rand_release[%0d]: got ren=%b wen=%b busy=%b ack=%b err=%b required 0 0 1 000 000",
                 n, r_ren, r_wen, r_busy, r_ack, r_err);
      end
      s_ack = 1'b0;
      clear_reqs();
      ptr = (w + 1) % MC;
      tick();
      checks++;
      if ({r_busy, r_gid} !== {1'b0, 2'(w)}) begin
        errors++;
        $display("FAIL rand_back_idle[%0d]: got busy=%b gid=%0d required busy=0 gid=%0d", n, r_busy, r_gid, w);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    clear_reqs();
    s_ack   = 1'b0;
    s_rdata = '0;
    test_reset();
    test_single_write();
    test_read_return();
    test_rr_fairness();
    test_hold_mid_txn();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minibus_arbiter.md
Name: minibus_arbiter

Overview:
- Shares one minibus master port between MASTER_COUNT requesters, e.g. instruction fetch, data access and a debug/DMA port, ahead of minibus_decoder.
- Grants one requester at a time using round-robin or fixed priority.
- Latches the winner's request and drives it onto the downstream bus.
- Routes ack/rdata back to the winner only, with an optional no-ack timeout.

Parameters:
MASTER_COUNT, 2, number of requesters (2..8)
ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, index 0 highest
TIMEOUT_CYCLES, 0, cycles in BUSY without s_ack before error-abort; 0 disables the timeout
IDW, $clog2(MASTER_COUNT) (min 1), grant index width (derived)

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
m_addr  in  MASTER_COUNT*32  per-requester address, requester i at [32i+:32]
m_width  in  MASTER_COUNT*2  per-requester width (00 byte, 01 half, 10 word)
m_wdata  in  MASTER_COUNT*32  per-requester write data
m_ren  in  MASTER_COUNT  per-requester read request
m_wen  in  MASTER_COUNT  per-requester write request
m_ack  out  MASTER_COUNT  one-hot completion pulse to the granted requester
m_err  out  MASTER_COUNT  one-hot timeout pulse to the granted requester
m_rdata  out  32  read data, broadcast; valid only with m_ack
s_addr  out  32  downstream address (registered)
s_width  out  2  downstream width (registered)
s_wdata  out  32  downstream write data (registered)
s_ren  out  1  downstream read enable (registered)
s_wen  out  1  downstream write enable (registered)
s_ack  in  1  downstream completion, one-cycle pulse or level
s_rdata  in  32  downstream read data
grant_id  out  IDW  index of the current/last granted requester
busy  out  1  high in BUSY and RELEASE

Behaviour:
- Reset (nrst low, asynchronous): state IDLE, every output 0, RR pointer 0. Reset mid-transaction aborts it silently with no ack/err.
- Request for requester i is req[i] = m_ren[i] | m_wen[i].
- If both m_ren[i] and m_wen[i] are set, the request is a write: s_wen=1, s_ren=0.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE, any req at edge k:
  - Select the winner. Round-robin: first set req scanning upward from the pointer, wrapping. Fixed: lowest set index.
  - Latch the winner's addr/width/wdata/ren/wen into the s_* registers, set grant_id, go to BUSY.
  - s_ren/s_wen are visible from cycle k+1, giving one cycle grant latency.
  - No req: stay in IDLE with s_ren = s_wen = 0.
- BUSY:
  - s_* hold the latched values. Changes on m_* inputs, including the winner dropping its request, are ignored; the transaction completes.
  - s_ack high: m_ack[grant_id] = 1 and m_rdata = s_rdata combinationally in that same cycle.
  - At the next edge, clear s_ren/s_wen and go to RELEASE.
  - Timeout: with TIMEOUT_CYCLES = T > 0, if T consecutive BUSY cycles pass without s_ack, pulse m_err[grant_id] for one cycle, clear s_ren/s_wen and go to RELEASE. The counter clears on entry to BUSY.
- RELEASE:
  - Exactly one cycle. m_ack = m_err = 0; s_ack is ignored and not forwarded.
  - This gives the requester time to drop ren/wen after its ack.
  - Round-robin: pointer = grant_id+1, wrapping to 0 at MASTER_COUNT.
  - Return to IDLE.
- m_ack/m_err are never asserted for a non-granted index or outside BUSY, and at most one bit is high.
- m_rdata = 0 whenever m_ack is all zero.
- Back-to-back throughput: at most one transaction per (3 + downstream latency) cycles.
- A requester still holding its request in IDLE after RELEASE is re-arbitrated normally. A stale request is the master's responsibility.

Test Plan:
1. Single write: reset; requester 0 writes addr 0x4000, width 10, data 0x12345678 → s_wen=1 and s_addr=0x4000 one cycle later; s_ack → m_ack=01 same cycle; s_wen=0 next cycle; busy low after RELEASE.
2. Read data return: requester 1 reads 0x0000; slave returns 0xBEEFBEEF with s_ack → m_ack=10, m_rdata=0xBEEFBEEF in that cycle, m_ack[0] never set.
3. Round-robin fairness: both requesters hold requests continuously for 4 transactions → grant_id sequence 0,1,0,1. With ROUND_ROBIN=0 → 0,0,0,0.
4. Request change mid-transaction: requester 0 granted with addr 0x10; in BUSY it changes m_addr to 0x20 and drops ren → s_addr stays 0x10, s_ren held until s_ack, m_ack[0] still pulses.
5. Timeout: TIMEOUT_CYCLES=4, s_ack never asserted → m_err[grant_id] pulses exactly 4 cycles after BUSY entry, s_ren cleared, FSM back in IDLE 2 cycles later.
6. Async reset mid-BUSY: drop nrst between edges → all outputs 0 immediately, no m_ack; after release, a new request is granted with pointer 0.
